// File: rtl/sat_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sat_arith_pkg
// Purpose  : Saturation limits and overflow-kind enum shared by the saturating
//            adder and subtractor datapaths.
// Revision : 1.0 - initial release
// ============================================================================
package sat_arith_pkg;

    // Limit functions return this fixed width; callers size-cast down to P (P <= 256).
    localparam int unsigned SAT_FN_W = 256;

    typedef enum logic [1:0] {
        OVF_NONE = 2'd0,
        OVF_POS  = 2'd1,
        OVF_NEG  = 2'd2
    } ovf_kind_e;

    function automatic logic [SAT_FN_W-1:0] sat_max(input int unsigned p);
        logic [SAT_FN_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i + 1 < p; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [SAT_FN_W-1:0] sat_min(input int unsigned p);
        logic [SAT_FN_W-1:0] r;
        r = '0;
        r[p-1] = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_sub.sv
`default_nettype none
// ============================================================================
// Module   : sat_sub
// Purpose  : Combinational saturating two's-complement subtract, diff = sat(a - b).
// Revision : 1.0 - initial release
// ============================================================================
module sat_sub
    import sat_arith_pkg::*;
#(
    parameter int P = 32
) (
    input  logic [P-1:0] a,
    input  logic [P-1:0] b,
    output logic [P-1:0] diff,
    output logic         sat
);

    localparam logic [P-1:0] c_max = P'(sat_max(P));
    localparam logic [P-1:0] c_min = P'(sat_min(P));

    logic [P-1:0] w_raw;
    ovf_kind_e    w_kind;

    assign w_raw = a - b;

    // Overflow only possible when operand signs differ; the raw sign then tells which way.
    always_comb begin
        w_kind = OVF_NONE;
        if (!a[P-1] && b[P-1] && w_raw[P-1]) begin
            w_kind = OVF_POS;
        end else if (a[P-1] && !b[P-1] && !w_raw[P-1]) begin
            w_kind = OVF_NEG;
        end
    end

    always_comb begin
        diff = w_raw;
        case (w_kind)
            OVF_POS: diff = c_max;
            OVF_NEG: diff = c_min;
            default: diff = w_raw;
        endcase
    end

    assign sat = (w_kind != OVF_NONE);

endmodule
`default_nettype wire

// File: rtl/sat_sub_stream.sv
`default_nettype none
// ============================================================================
// Module   : sat_sub_stream
// Purpose  : Two-stage valid/ready pipelined saturating subtractor with a
//            sticky saturation event counter.
// Revision : 1.0 - initial release
// ============================================================================
module sat_sub_stream
    import sat_arith_pkg::*;
#(
    parameter int P     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P-1:0]     in_a,
    input  logic [P-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P-1:0]     out_diff,
    output logic             out_sat,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_s1_valid;
    logic [P-1:0]     r_s1_a;
    logic [P-1:0]     r_s1_b;
    logic             r_s2_valid;
    logic [P-1:0]     r_diff;
    logic             r_sat;
    logic [CNT_W-1:0] r_cnt;

    logic [P-1:0]     w_diff;
    logic             w_sat;
    logic             w_s2_load;
    logic             w_in_xfer;
    logic             w_out_xfer;

    sat_sub #(
        .P (P)
    ) u_sat_sub (
        .a    (r_s1_a),
        .b    (r_s1_b),
        .diff (w_diff),
        .sat  (w_sat)
    );

    // in_ready depends only on state and out_ready, never on in_valid.
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready   = !r_s1_valid || w_s2_load;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_s2_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_sat      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_diff     <= w_diff;
            r_sat      <= w_sat;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Clear takes priority over a coincident saturated delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear_stats) begin
            r_cnt <= '0;
        end else if (w_out_xfer && r_sat && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_diff  = r_diff;
    assign out_sat   = r_sat;
    assign sat_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sat_sub_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_sat_sub_stream
// Purpose  : Self-checking bench for sat_sub_stream (P=8) against a clamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sat_sub_stream;

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_diff;
    logic       out_sat;
    logic       clear_stats = 1'b0;
    logic [15:0] sat_count;

    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_diff2;
    logic       out_sat2;
    logic [1:0] sat_count2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit lat_mode = 1'b0;
    exp_t q[$];
    exp_t got[$];
    int m_cnt16 = 0;
    int m_cnt2 = 0;
    bit hold = 1'b0;
    logic [7:0] h_d;
    logic h_s;

    sat_sub_stream #(.P(8), .CNT_W(16)) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .in_a (in_a), .in_b (in_b),
        .out_valid (out_valid), .out_ready (out_ready), .out_diff (out_diff), .out_sat (out_sat),
        .clear_stats (clear_stats), .sat_count (sat_count)
    );

    // Same stimulus, narrow counter to exercise the sticky limit.
    sat_sub_stream #(.P(8), .CNT_W(2)) dut2 (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready2), .in_a (in_a), .in_b (in_b),
        .out_valid (out_valid2), .out_ready (out_ready), .out_diff (out_diff2), .out_sat (out_sat2),
        .clear_stats (clear_stats), .sat_count (sat_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int c);
        exp_t m;
        int   r;
        r = int'($signed(a)) - int'($signed(b));
        m.cyc = c;
        if (r > 127) begin
            m.d = 8'd127; m.s = 1'b1;
        end else if (r < -128) begin
            m.d = 8'h80;  m.s = 1'b1;
        end else begin
            m.d = 8'(r);  m.s = 1'b0;
        end
        return m;
    endfunction

    // Scoreboard: inputs are stable around negedge, so everything is sampled there.
    always @(negedge clk) begin
        exp_t e;
        bit   xfer_sat;
        cyc++;
        if (rst) begin
            q.delete();
            m_cnt16 = 0;
            m_cnt2  = 0;
            hold    = 1'b0;
        end else begin
            xfer_sat = 1'b0;
            check("sat_count", 32'(sat_count), m_cnt16);
            check("sat_count_w2", 32'(sat_count2), m_cnt2);
            check("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            check("dut2_out_diff", 32'(out_diff2), 32'(out_diff));
            if (hold) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_diff", 32'(out_diff), 32'(h_d));
                check("hold_sat", 32'(out_sat), 32'(h_s));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 0);
                end else begin
                    e = q[0];
                    if (!hold && lat_mode) check("latency", cyc - e.cyc, 2);
                    check("out_diff", 32'(out_diff), 32'(e.d));
                    check("out_sat", 32'(out_sat), 32'(e.s));
                    if (out_ready) begin
                        void'(q.pop_front());
                        got.push_back(e);
                        xfer_sat = e.s;
                    end
                end
            end
            if (clear_stats) begin
                m_cnt16 = 0;
                m_cnt2  = 0;
            end else if (xfer_sat) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            hold = out_valid && !out_ready;
            h_d  = out_diff;
            h_s  = out_sat;
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, cyc));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!acc) check("send_timeout", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] da[5];
        logic [7:0] db[5];
        logic [7:0] ed[5];
        logic       es[5];
        int         nacc;
        int         ec[5];
        bit         done;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_diff", 32'(out_diff), 0);
        check("rst_out_sat", 32'(out_sat), 0);
        check("rst_sat_count", 32'(sat_count), 0);
        rst = 1'b0;
        step(1);
        check("post_rst_in_ready", 32'(in_ready), 1);

        // ---------------- directed stream ----------------
        da = '{8'd5, 8'd100, 8'h9C, 8'hFF, 8'd0};
        db = '{8'd3, 8'h9C, 8'd100, 8'h80, 8'h80};
        ed = '{8'd2, 8'd127, 8'h80, 8'd127, 8'd127};
        es = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        lat_mode  = 1'b1;
        got.delete();
        for (int i = 0; i < 5; i++) send(da[i], db[i]);
        step(4);
        check("directed_count", got.size(), 5);
        if (got.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("directed_diff[%0d]", i), 32'(got[i].d), 32'(ed[i]));
                check($sformatf("directed_sat[%0d]", i), 32'(got[i].s), 32'(es[i]));
            end
        end
        lat_mode = 1'b0;

        // ---------------- backpressure ----------------
        got.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 8'd10; in_b = 8'd1;
        nacc = 0;
        repeat (5) begin
            bit a;
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
            if (a) begin
                nacc++;
                in_a = in_a + 8'd1;
            end
        end
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_accepted", nacc, 2);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(4);
        check("bp_delivered", got.size(), 2);
        if (got.size() == 2) begin
            check("bp_first", 32'(got[0].d), 9);
            check("bp_second", 32'(got[1].d), 10);
        end

        // ---------------- sticky counter (CNT_W=2) and clear ----------------
        clear_stats = 1'b1;
        step(1);
        clear_stats = 1'b0;
        ec = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            send(8'd100, 8'h9C);
            step(3);
            check($sformatf("cnt_w2[%0d]", i), 32'(sat_count2), ec[i]);
        end
        check("cnt_w16_after5", 32'(sat_count), 5);
        send(8'd100, 8'h9C);
        step(1);
        clear_stats = 1'b1;
        step(1);
        clear_stats = 1'b0;
        check("clear_wins_w16", 32'(sat_count), 0);
        check("clear_wins_w2", 32'(sat_count2), 0);

        // ---------------- random ----------------
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [7:0] ra;
                    logic [7:0] rb;
                    int k;
                    k = int'($urandom_range(0, 2));
                    if (k > 0) step(k);
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    if ($urandom_range(0, 7) == 0) rb = 8'h80;
                    if ($urandom_range(0, 15) == 0) ra = 8'hFF;
                    send(ra, rb);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready   = ($urandom_range(0, 3) != 0);
                    clear_stats = ($urandom_range(0, 499) == 0);
                end
                clear_stats = 1'b0;
            end
        join
        out_ready = 1'b1;
        step(6);
        check("random_drained", q.size(), 0);
        check("random_sat_count", 32'(sat_count), m_cnt16);

        // ---------------- reset with entries in flight ----------------
        out_ready = 1'b0;
        send(8'd100, 8'h9C);
        send(8'h9C, 8'd100);
        step(1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_sat_count", 32'(sat_count), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        step(1);
        rst = 1'b0;
        out_ready = 1'b1;
        lat_mode  = 1'b1;
        got.delete();
        send(8'd7, 8'hFF);
        step(4);
        check("post_rst_count", got.size(), 1);
        if (got.size() == 1) check("post_rst_diff", 32'(got[0].d), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
